// File: rtl/regfile_param.sv
// Parametrised register file with two registered read ports, one write port,
// same-cycle write-to-read bypass, optional hardwired-zero entry 0 and a clear sweep.
module regfile_param #(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             readEn,
    input  logic             writeEn,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             clear,
    output logic [WIDTH-1:0] readOut1,
    output logic [WIDTH-1:0] readOut2,
    output logic             readValid,
    output logic             busy,
    output logic             writeErr
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state_reg, state_next;
    logic [AW-1:0]    ptr_reg, ptr_next;
    logic [WIDTH-1:0] rf_word [DEPTH];
    logic [WIDTH-1:0] rd1_data, rd2_data;
    logic             rd_ok, wr_store, wr_drop, byp1, byp2;

    assign busy = (state_reg == CLEAR);

    // Index decode: out-of-range indices and the hardwired zero entry never match.
    always_comb begin
        rd_ok    = 1'b0;
        rd1_data = '0;
        rd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG != 0 && i == 0)) begin
                if (rd == AW'(i))  rd_ok    = 1'b1;
                if (rs1 == AW'(i)) rd1_data = rf_word[i];
                if (rs2 == AW'(i)) rd2_data = rf_word[i];
            end
        end
    end

    assign wr_store = en & writeEn & ~busy & rd_ok;
    assign wr_drop  = en & writeEn & busy;
    assign byp1     = wr_store & (rd == rs1);
    assign byp2     = wr_store & (rd == rs2);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        if (en) begin
            case (state_reg)
                IDLE: begin
                    if (clear) begin
                        state_next = CLEAR;
                        ptr_next   = '0;
                    end
                end
                CLEAR: begin
                    ptr_next = ptr_reg + 1'b1;
                    if (ptr_reg == AW'(DEPTH - 1)) begin
                        state_next = IDLE;
                        ptr_next   = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // One storage word per entry; the sweep has priority but never meets an accepted write.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
            logic [WIDTH-1:0] cell_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cell_reg <= '0;
                end else if (en) begin
                    if (busy && ptr_reg == AW'(gi)) begin
                        cell_reg <= '0;
                    end else if (wr_store && rd == AW'(gi)) begin
                        cell_reg <= dataIn;
                    end
                end
            end
            assign rf_word[gi] = cell_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readOut1  <= '0;
            readOut2  <= '0;
            readValid <= 1'b0;
            writeErr  <= 1'b0;
        end else if (en) begin
            writeErr <= wr_drop;
            if (readEn) begin
                readOut1  <= byp1 ? dataIn : rd1_data;
                readOut2  <= byp2 ? dataIn : rd2_data;
                readValid <= 1'b1;
            end else begin
                readValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Drives a 32x32 zero-reg file and an 8x20 plain file with identical stimulus and
// compares both against a behavioural model every cycle.
module tb_regfile_param;

    logic        clk, rst_n;
    logic        en_t, re_t, we_t, clr_t;
    logic [4:0]  rs1_t, rs2_t, rd_t;
    logic [31:0] din_t;

    logic [31:0] oa1, oa2;
    logic        va, ba, ea;
    logic [7:0]  ob1, ob2;
    logic        vb, bb, eb;

    int passes = 0;
    int checks = 0;
    int bcnt_a, bcnt_b, cycle_no;

    // Reference model: index 0 = 32x32 zero-reg, index 1 = 8x20 plain.
    logic [31:0] mem [2][32];
    int          depth [2] = '{32, 20};
    bit          zr    [2] = '{1'b1, 1'b0};
    logic [31:0] msk   [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] m_o1 [2], m_o2 [2];
    bit          m_v [2], m_e [2], m_busy [2];
    int          m_ptr [2];

    regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(rst_n), .en(en_t), .readEn(re_t), .writeEn(we_t),
        .rs1(rs1_t), .rs2(rs2_t), .rd(rd_t), .dataIn(din_t), .clear(clr_t),
        .readOut1(oa1), .readOut2(oa2), .readValid(va), .busy(ba), .writeErr(ea)
    );

    regfile_param #(.WIDTH(8), .DEPTH(20), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(rst_n), .en(en_t), .readEn(re_t), .writeEn(we_t),
        .rs1(rs1_t), .rs2(rs2_t), .rd(rd_t), .dataIn(din_t[7:0]), .clear(clr_t),
        .readOut1(ob1), .readOut2(ob2), .readValid(vb), .busy(bb), .writeErr(eb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    function automatic void mreset(int k);
        for (int i = 0; i < 32; i++) mem[k][i] = '0;
        m_o1[k] = '0; m_o2[k] = '0;
        m_v[k] = 0; m_e[k] = 0; m_busy[k] = 0; m_ptr[k] = 0;
    endfunction

    function automatic logic [31:0] mread(int k, logic [4:0] a, bit st, logic [31:0] d);
        if (st && rd_t == a) return d;
        if (int'(a) >= depth[k] || (zr[k] && a == 5'd0)) return '0;
        return mem[k][a];
    endfunction

    function automatic void mstep(int k);
        logic [31:0] d;
        bit st;
        if (!rst_n) begin
            mreset(k);
            return;
        end
        if (!en_t) return;
        d  = din_t & msk[k];
        st = we_t && !m_busy[k] && int'(rd_t) < depth[k] && !(zr[k] && rd_t == 5'd0);
        if (re_t) begin
            m_o1[k] = mread(k, rs1_t, st, d);
            m_o2[k] = mread(k, rs2_t, st, d);
            m_v[k]  = 1;
        end else begin
            m_v[k] = 0;
        end
        m_e[k] = we_t && m_busy[k];
        if (st) mem[k][rd_t] = d;
        if (m_busy[k]) begin
            mem[k][m_ptr[k]] = '0;
            m_ptr[k]++;
            if (m_ptr[k] == depth[k]) m_busy[k] = 0;
        end else if (clr_t) begin
            m_busy[k] = 1;
            m_ptr[k]  = 0;
        end
    endfunction

    task automatic cmp_all();
        chk("A_out1", oa1, m_o1[0]);
        chk("A_out2", oa2, m_o2[0]);
        chk("A_valid", 32'(va), 32'(m_v[0]));
        chk("A_busy", 32'(ba), 32'(m_busy[0]));
        chk("A_werr", 32'(ea), 32'(m_e[0]));
        chk("B_out1", 32'(ob1), m_o1[1]);
        chk("B_out2", 32'(ob2), m_o2[1]);
        chk("B_valid", 32'(vb), 32'(m_v[1]));
        chk("B_busy", 32'(bb), 32'(m_busy[1]));
        chk("B_werr", 32'(eb), 32'(m_e[1]));
    endtask

    task automatic cyc(input bit e, input bit re, input bit we, input int a1, input int a2,
                       input int w, input logic [31:0] d, input bit c);
        en_t = e; re_t = re; we_t = we; clr_t = c;
        rs1_t = 5'(a1); rs2_t = 5'(a2); rd_t = 5'(w); din_t = d;
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
        cycle_no++;
        cmp_all();
        if (ba) bcnt_a++;
        if (bb) bcnt_b++;
        $display("cyc %0d rst_n=%b en=%b re=%b we=%b rs1=%0d rs2=%0d rd=%0d d=%h clr=%b | A %h %h v=%b b=%b e=%b | B %h %h v=%b b=%b e=%b",
                 cycle_no, rst_n, e, re, we, rs1_t, rs2_t, rd_t, d, c, oa1, oa2, va, ba, ea, ob1, ob2, vb, bb, eb);
    endtask

    initial begin
        cycle_no = 0;
        rst_n = 1'b0;
        mreset(0);
        mreset(1);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Fill and readback
        for (int i = 1; i < 32; i++) cyc(1, 0, 1, 0, 0, i, 32'(i + 100), 0);
        for (int i = 0; i < 32; i++) cyc(1, 1, 0, i, 31 - i, 0, 0, 0);
        cyc(1, 1, 0, 7, 24, 0, 0, 0);
        chk("fill_A1", oa1, 32'd107);
        chk("fill_A2", oa2, 32'd124);
        chk("fill_B1", 32'(ob1), 32'h6B);
        chk("fill_B_oor", 32'(ob2), 32'h0);

        // Bypass, and writes to entry 0 / out-of-range entry
        cyc(1, 0, 1, 0, 0, 5, 32'h11, 0);
        cyc(1, 1, 1, 5, 5, 5, 32'hAA, 0);
        chk("byp_A1", oa1, 32'hAA);
        chk("byp_A2", oa2, 32'hAA);
        cyc(1, 1, 1, 0, 5, 0, 32'hDEAD_BEEF, 0);
        chk("byp_zero_A", oa1, 32'h0);
        chk("byp_r0_B", 32'(ob1), 32'hEF);
        cyc(1, 0, 1, 0, 0, 0, 32'h5A, 0);
        cyc(1, 0, 1, 0, 0, 25, 32'h77, 0);
        chk("oor_werr_B", 32'(eb), 32'h0);
        cyc(1, 1, 0, 0, 25, 0, 0, 0);
        chk("r0_A", oa1, 32'h0);
        chk("r0_B", 32'(ob1), 32'h5A);
        chk("r25_B", 32'(ob2), 32'h0);

        // Clear sweep with a dropped write and a re-asserted clear
        bcnt_a = 0; bcnt_b = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        for (int j = 0; j < 60 && (ba || bb); j++) begin
            if (j == 4) begin
                cyc(1, 1, 1, 3, 4, 3, 32'h3333, 0);
                chk("drop_werr_A", 32'(ea), 32'h1);
                chk("drop_werr_B", 32'(eb), 32'h1);
            end else begin
                cyc(1, 1, 0, j, 31 - j, 0, 0, j == 10);
            end
        end
        chk("busy_len_A", 32'(bcnt_a), 32'd32);
        chk("busy_len_B", 32'(bcnt_b), 32'd20);
        for (int i = 0; i < 32; i++) begin
            cyc(1, 1, 0, i, i, 0, 0, 0);
            chk("clr_rd_A", oa1, 32'h0);
        end

        // en gating mid-sweep
        for (int i = 0; i < 32; i++) cyc(1, 0, 1, 0, 0, i, $urandom, 0);
        bcnt_a = 0; bcnt_b = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        for (int j = 0; j < 7; j++) cyc(1, 1, 0, j, j + 8, 0, 0, 0);
        for (int j = 0; j < 5; j++) cyc(0, 1, 1, 20 + j, j, 25 + j, $urandom, 0);
        for (int j = 0; j < 60 && (ba || bb); j++) cyc(1, 1, 0, j, 31 - j, 0, 0, 0);
        chk("gated_len_A", 32'(bcnt_a), 32'd37);
        chk("gated_len_B", 32'(bcnt_b), 32'd25);

        // Asynchronous reset mid-sweep
        for (int i = 0; i < 32; i++) cyc(1, 0, 1, 0, 0, i, $urandom | 32'h1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        for (int j = 0; j < 9; j++) cyc(1, 1, 0, j + 20, j + 1, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        mreset(0);
        mreset(1);
        cmp_all();
        chk("arst_busy_A", 32'(ba), 32'h0);
        chk("arst_valid_B", 32'(vb), 32'h0);
        cyc(1, 1, 1, 1, 2, 3, 32'h1234, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cyc(1, 1, 0, i, 31 - i, 0, 0, 0);
            chk("post_rst_A", oa1, 32'h0);
        end
        bcnt_a = 0; bcnt_b = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        for (int j = 0; j < 60 && (ba || bb); j++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_len_A", 32'(bcnt_a), 32'd32);
        chk("post_rst_len_B", 32'(bcnt_b), 32'd20);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                $urandom, $urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised, registered-read register file: two read ports, one write port, same-cycle write-to-read bypass, optional hardwired-zero entry 0, and a clear sequencer that zeroes the whole array in DEPTH cycles. It generalises the 32 x 32-bit file in width and depth. It sits between decode (rs1/rs2/rd) and the execute stage, and `readOut1`/`readOut2` feed the operand latches directly.

## Interface
- WIDTH, 32, data width in bits (>= 1)
- DEPTH, 32, number of entries (>= 2; need not be a power of two)
- ZERO_REG, 1, 1: entry 0 reads as 0 and ignores writes; 0: entry 0 is an ordinary register
- AW (localparam), $clog2(DEPTH), index width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  global enable; when 0 no state changes (array, outputs, sequencer all hold)
- readEn  in  1  read request for both ports
- writeEn  in  1  write request
- rs1, rs2  in  AW  read indices
- rd  in  AW  write index
- dataIn  in  WIDTH  write data
- clear  in  1  start clear sweep (level-sampled)
- readOut1, readOut2  out  WIDTH  registered read data
- readValid  out  1  readOut* updated at the last edge
- busy  out  1  clear sweep in progress
- writeErr  out  1  one-cycle pulse: the previous cycle's write was dropped

## Operation
- Reset (reset=0, any time, including mid-sweep):
  - all entries are 0;
  - readOut1/readOut2 are 0;
  - readValid, busy and writeErr are 0;
  - the sequencer is in IDLE and the sweep pointer is 0.
- Write accepted when `en & writeEn & !busy`:
  - in-range rd with (ZERO_REG=0 or rd!=0): rf[rd] <= dataIn;
  - rd==0 with ZERO_REG=1, or rd >= DEPTH: silently ignored, no writeErr.
- Write dropped when `en & writeEn & busy`: the array is unchanged and writeErr is 1 for the following cycle.
- Read when `en & readEn`, per port:
  - readOutN <= bypass ? dataIn : rf[rsN];
  - readValid <= 1;
  - bypass = write accepted this cycle, actually stores, and rd==rsN;
  - rsN >= DEPTH, or rsN==0 with ZERO_REG=1, returns 0.
- Otherwise (en=1, readEn=0): readOut* hold and readValid <= 0.
- en=0: readValid and writeErr hold their values, as does all other state.
- Sequencer, two states:
  - IDLE -> CLEAR when `en & clear`; ptr <= 0.
  - CLEAR, each edge with en=1: rf[ptr] <= 0 and ptr <= ptr+1. After clearing DEPTH-1 -> IDLE.
  - CLEAR with en=0: pauses, ptr holds.
  - clear in CLEAR: ignored (no restart).
- busy = (state == CLEAR), registered.
- Read during CLEAR is allowed:
  - returns pre-edge contents, so the entry being cleared at that edge reads its old value;
  - already-swept entries read 0.
- Write and clear in the same IDLE cycle: the write is accepted, then erased by the sweep.

## Timing
- Read latency: 1 cycle, with readOut* and readValid valid after the edge that sampled readEn.
- Write visibility:
  - through the bypass on the same-cycle read;
  - via the array on any read issued at least 1 cycle later.
- busy:
  - rises at the edge sampling clear;
  - stays high for exactly DEPTH enabled cycles;
  - falls at the edge that clears entry DEPTH-1.
- A write presented in the cycle busy falls is dropped, because busy is still 1 before that edge.
- writeErr: high for exactly one cycle, the cycle after the dropped write.
- Reset is asynchronous: outputs go to their reset values without a clock edge.
- Reset release is synchronous to the next clk edge; the first operation is accepted at the first rising edge with reset=1.

## Test plan
- Fill and readback, WIDTH=32, DEPTH=32, ZERO_REG=1:
  - stimulus: write rf[i]=i+100 for i=1..31, then read rs1=i, rs2=31-i;
  - response: readOut1=i+100 and readOut2=131-i one cycle later; readOut for index 0 = 0; a write of 0xDEADBEEF to rd=0 still reads 0.
- Bypass:
  - stimulus: in the same cycle, rd=rs1=rs2=5, dataIn=0x0000_00AA, old rf[5]=0x11;
  - response: next cycle readOut1=readOut2=0xAA.
  - With ZERO_REG=1 and rd=rs1=0: readOut1=0.
- Clear sweep, DEPTH=32:
  - stimulus: pulse clear, then write rd=3 during busy;
  - response: busy high for exactly 32 cycles; writeErr=1 the cycle after the write; all entries read 0 after busy falls.
  - Clear re-asserted mid-sweep: busy length is unchanged.
- en gating:
  - stimulus: drop en for 5 cycles mid-sweep;
  - response: busy extends to 37 cycles; during en=0, readOut*, readValid and the array are unchanged despite readEn/writeEn=1.
- Non-power-of-two configuration, WIDTH=8, DEPTH=20, ZERO_REG=0:
  - stimulus: write rd=0 (value 0x5A), then rd=25 (value 0x77);
  - response: rf[0] reads 0x5A; the rd=25 write is ignored with no writeErr; rs1=25 reads 0; the clear sweep takes 20 cycles.
- Asynchronous reset mid-sweep:
  - stimulus: assert reset at sweep cycle 10 between clock edges;
  - response: busy, readOut*, readValid and writeErr go to 0 immediately; after release, all entries read 0; a new clear starts from ptr=0.
